// File: rtl/power_pkg.sv
// power_pkg: shared state encoding and saturating-increment helper for clock gating control.
package power_pkg;
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_GATED = 2'd1,
        ST_WAKE  = 2'd2
    } state_t;

    function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] max);
        return (v == max) ? v : v + 64'd1;
    endfunction
endpackage

// File: rtl/clock_gate_controller_sat_counter.sv
// sat_counter: saturating statistics counter with synchronous clear.
module sat_counter
    import power_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);
    localparam logic [WIDTH-1:0] MAX = '1;

    // clear wins over a same-cycle increment
    always_ff @(posedge clk_in) begin
        if (rst || clr)
            count <= '0;
        else if (inc)
            count <= WIDTH'(sat_inc(64'(count), 64'(MAX)));
    end
endmodule

// File: rtl/clock_gate_controller.sv
// clock_gate_controller: idle detector and sleep/wake sequencer driving a clock gating cell enable.
module clock_gate_controller
    import power_pkg::*;
#(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_WIDTH   = 8,
    parameter int STAT_WIDTH  = 32,
    parameter int EVT_WIDTH   = 16
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic                  busy,
    input  logic                  wake_req,
    input  logic                  force_on,
    input  logic                  stat_clr,
    output logic                  clk_en,
    output logic                  gated,
    output logic                  wake_ack,
    output logic [STAT_WIDTH-1:0] gated_cycles,
    output logic [EVT_WIDTH-1:0]  gate_events
);
    state_t               state;
    logic [CNT_WIDTH-1:0] idle_cnt;
    logic [CNT_WIDTH-1:0] wake_cnt;
    logic                 idle;
    logic                 gate_now;
    logic                 wake_done;

    assign idle      = !busy && !wake_req && !force_on;
    assign gate_now  = (state == ST_RUN) && idle && (idle_cnt == CNT_WIDTH'(IDLE_CYCLES - 1));
    assign wake_done = wake_cnt == CNT_WIDTH'(WAKE_CYCLES - 1);

    // outputs are registered alongside the state so nothing is combinational from inputs
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state    <= ST_RUN;
            idle_cnt <= '0;
            wake_cnt <= '0;
            clk_en   <= 1'b1;
            gated    <= 1'b0;
            wake_ack <= 1'b0;
        end else begin
            wake_ack <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (gate_now) begin
                        state    <= ST_GATED;
                        idle_cnt <= '0;
                        clk_en   <= 1'b0;
                        gated    <= 1'b1;
                    end else begin
                        idle_cnt <= idle ? idle_cnt + 1'b1 : '0;
                    end
                end
                ST_GATED: begin
                    if (!idle) begin
                        state    <= ST_WAKE;
                        wake_cnt <= '0;
                        clk_en   <= 1'b1;
                        gated    <= 1'b0;
                    end
                end
                ST_WAKE: begin
                    wake_cnt <= wake_cnt + 1'b1;
                    if (wake_done) begin
                        state    <= ST_RUN;
                        idle_cnt <= '0;
                        wake_ack <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_RUN;
                    idle_cnt <= '0;
                    clk_en   <= 1'b1;
                    gated    <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(.WIDTH(STAT_WIDTH)) u_gated_cycles (
        .clk_in (clk_in),
        .rst    (rst),
        .inc    (state == ST_GATED),
        .clr    (stat_clr),
        .count  (gated_cycles)
    );

    sat_counter #(.WIDTH(EVT_WIDTH)) u_gate_events (
        .clk_in (clk_in),
        .rst    (rst),
        .inc    (gate_now),
        .clr    (stat_clr),
        .count  (gate_events)
    );
endmodule

// File: tb/tb_clock_gate_controller.sv
// tb_clock_gate_controller: scoreboard bench comparing the controller against a cycle-level behavioural model.
module tb_clock_gate_controller;
    localparam int IDLE = 16;
    localparam int WAKE = 2;
    localparam int GC_MAX = 15;
    localparam int GE_MAX = 7;

    typedef struct {
        logic       ce;
        logic       g;
        logic       ack;
        logic [3:0] gc;
        logic [2:0] ge;
    } exp_t;

    logic       clk_in = 0;
    logic       rst = 1;
    logic       busy = 0;
    logic       wake_req = 0;
    logic       force_on = 0;
    logic       stat_clr = 0;
    logic       clk_en;
    logic       gated;
    logic       wake_ack;
    logic [3:0] gated_cycles;
    logic [2:0] gate_events;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    // model state: 0 running, 1 clock stopped, 2 waking
    int mode = 0;
    int run_len = 0;
    int wake_left = 0;
    int gc = 0;
    int ge = 0;
    logic ack = 0;

    always #5 clk_in = ~clk_in;

    clock_gate_controller #(
        .IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE), .CNT_WIDTH(8), .STAT_WIDTH(4), .EVT_WIDTH(3)
    ) dut (
        .clk_in(clk_in), .rst(rst), .busy(busy), .wake_req(wake_req), .force_on(force_on),
        .stat_clr(stat_clr), .clk_en(clk_en), .gated(gated), .wake_ack(wake_ack),
        .gated_cycles(gated_cycles), .gate_events(gate_events)
    );

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: got=%0d want=%0d", n, $time, act, req);
        end
    endtask

    task automatic cyc(input logic b, input logic w, input logic f, input logic c, input logic r);
        logic idl;
        logic gc_inc;
        logic ge_inc;
        exp_t e;
        busy = b; wake_req = w; force_on = f; stat_clr = c; rst = r;
        @(posedge clk_in);
        idl = !b && !w && !f;
        if (r) begin
            mode = 0; run_len = 0; wake_left = 0; gc = 0; ge = 0; ack = 0;
        end else begin
            gc_inc = (mode == 1);
            ge_inc = 0;
            ack = 0;
            if (mode == 0) begin
                run_len = idl ? run_len + 1 : 0;
                if (run_len == IDLE) begin
                    mode = 1; run_len = 0; ge_inc = 1;
                end
            end else if (mode == 1) begin
                if (!idl) begin
                    mode = 2; wake_left = WAKE;
                end
            end else begin
                wake_left--;
                if (wake_left == 0) begin
                    mode = 0; run_len = 0; ack = 1;
                end
            end
            if (c) begin
                gc = 0; ge = 0;
            end else begin
                if (gc_inc && gc < GC_MAX) gc++;
                if (ge_inc && ge < GE_MAX) ge++;
            end
        end
        e.ce = (mode != 1);
        e.g = (mode == 1);
        e.ack = ack;
        e.gc = 4'(gc);
        e.ge = 3'(ge);
        q.push_back(e);
        #1;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    always @(negedge clk_in) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("clk_en", 32'(clk_en), 32'(e.ce));
            check("gated", 32'(gated), 32'(e.g));
            check("wake_ack", 32'(wake_ack), 32'(e.ack));
            check("gated_cycles", 32'(gated_cycles), 32'(e.gc));
            check("gate_events", 32'(gate_events), 32'(e.ge));
        end
    end

    initial begin
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        idle_n(20);
        cyc(0, 1, 0, 0, 0);
        idle_n(4);
        cyc(1, 0, 0, 0, 0);
        idle_n(10);
        cyc(1, 0, 0, 0, 0);
        idle_n(20);
        for (int i = 0; i < 30; i++) cyc(0, 0, 1, 0, 0);
        idle_n(40);
        cyc(0, 0, 0, 1, 0);
        idle_n(3);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        idle_n(20);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        idle_n(18);
        for (int i = 0; i < 4000; i++)
            cyc($urandom % 20 == 0, $urandom % 40 == 0, $urandom % 60 == 0,
                $urandom % 50 == 0, $urandom % 500 == 0);
        cyc(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk_in);
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/clock_gate_controller.md
# clock_gate_controller

Activity-based idle detector and sleep/wake sequencer that drives the `enable` input of `parameterized_clock_gating` directly upstream of it. It runs on the free-running (ungated) clock and watches a block's `busy` indication. After a programmable run of idle cycles it drops `clk_en`; on a wake cause it raises `clk_en` again and acknowledges once the downstream synchronizer has had time to pass the clock. It also keeps saturating statistics of gated cycles and gating events for power reporting.

## Interface
- IDLE_CYCLES, 16: consecutive idle samples required before gating; legal range ≥1.
- WAKE_CYCLES, 2: cycles from `clk_en` rising to `wake_ack`; legal range ≥1. Set equal to the gating cell's STAGES.
- CNT_WIDTH, 8: width of the idle and wake counters; must hold max(IDLE_CYCLES, WAKE_CYCLES).
- STAT_WIDTH, 32: width of `gated_cycles`.
- EVT_WIDTH, 16: width of `gate_events`.

Ports:
- clk_in  input  1  free-running clock (same clock as the gating cell's `clk_in`)
- rst  input  1  synchronous, active-high reset
- busy  input  1  gated domain has work in flight
- wake_req  input  1  external wake request (level)
- force_on  input  1  software override; holds clock enabled
- stat_clr  input  1  one-cycle pulse; clears both statistics counters
- clk_en  output  1  active-high enable to the gating cell
- gated  output  1  state is GATED
- wake_ack  output  1  one-cycle pulse; gated clock is running again
- gated_cycles  output  STAT_WIDTH  saturating count of cycles spent in GATED
- gate_events  output  EVT_WIDTH  saturating count of RUN→GATED transitions

## Operation
- The idle condition is `!busy && !wake_req && !force_on`. The wake condition is its complement.
- The FSM has three states: RUN, GATED, WAKE. All outputs are decoded from registers, so there are no combinational paths from inputs to outputs.
- RUN state:
  - `clk_en`=1.
  - When the idle condition holds: if `idle_cnt == IDLE_CYCLES-1`, go to GATED and clear `idle_cnt`. Otherwise increment `idle_cnt`.
  - Any non-idle sample clears `idle_cnt`.
- GATED state:
  - `clk_en`=0 and `gated`=1.
  - `gated_cycles` increments each cycle spent in GATED.
  - A wake condition sampled at an edge moves the FSM to WAKE and clears `wake_cnt`.
- WAKE state:
  - `clk_en`=1.
  - `wake_cnt` increments every cycle. Inputs are ignored, so the wake always completes.
  - When `wake_cnt == WAKE_CYCLES-1`, go to RUN and assert `wake_ack` for exactly the first RUN cycle.
  - `idle_cnt` starts from 0 on entry to RUN.
- `gate_events` increments on each RUN→GATED edge.
- Statistics saturate at all-ones and do not wrap.
- `stat_clr` zeroes both statistics counters. It takes priority over a same-cycle increment.

## Timing
- Reset values:
  - state=RUN, `clk_en`=1 (fail-safe: clock running), `gated`=0, `wake_ack`=0.
  - `idle_cnt`=0, `wake_cnt`=0, `gated_cycles`=0, `gate_events`=0.
- Gating latency: with the idle condition sampled true at edges 1..IDLE_CYCLES, `clk_en` is low from edge IDLE_CYCLES.
- A busy pulse at edge k<IDLE_CYCLES restarts the count. The next gating then occurs IDLE_CYCLES idle edges after k.
- Wake latency:
  - A wake condition sampled at edge w gives `clk_en`=1 from edge w.
  - State becomes RUN and `wake_ack`=1 from edge w+WAKE_CYCLES, for one cycle.
- Because the gating cell adds STAGES cycles of enable synchronization, `wake_ack` marks the first cycle of the downstream `clk_out` when WAKE_CYCLES=STAGES.
- Back-to-back: with the idle condition already true in the `wake_ack` cycle, re-gating happens IDLE_CYCLES edges after RUN entry. There is no hysteresis beyond IDLE_CYCLES.
- `rst` asserted in any state returns the block to RUN with `clk_en`=1 at the next edge. A partially completed wake produces no `wake_ack`.

## Structure
- Put in the shared `power_pkg`:
  - State encoding: RUN=2'd0, GATED=2'd1, WAKE=2'd2. The encoding 2'd3 is illegal and recovers to RUN.
  - A saturating-increment helper function.
- Use one sub-module, `sat_counter` (parameters: WIDTH; inputs: inc, clr), instantiated twice, once per statistics output.
- The FSM and the idle/wake counters sit in the top level. Target size is about 150–250 lines.

## Test plan
- Reset, then hold `busy`=0, `wake_req`=0, `force_on`=0 (IDLE_CYCLES=16):
  - `clk_en` stays 1 for 15 edges and is 0 from edge 16.
  - `gated`=1 and `gate_events`=1.
- Toggle `busy`=1 at idle count 10, then drop it:
  - The count restarts.
  - Gating occurs 16 edges after `busy` falls.
- From GATED, pulse `wake_req` for one cycle at edge w (WAKE_CYCLES=2):
  - `clk_en`=1 at w.
  - `wake_ack`=1 only at w+2.
  - `gated_cycles` equals the cycles spent in GATED.
- `force_on`=1 throughout: `clk_en` never drops.
  - Release it: gating occurs 16 idle edges later.
- Assert `rst` mid-WAKE: all outputs return to reset values and no `wake_ack` is produced.
- Use STAT_WIDTH=4 and gate for 20 cycles:
  - `gated_cycles` saturates at 15.
  - `stat_clr` coinciding with an increment leaves 0.
